hold_interpolator: RTL and testbench

- Interpolates a low-rate sample stream up to the high-rate strobe domain by factor rate+1, using either zero-order hold or zero-stuffing.
- Performs the inverse of the receive-path integrate-and-dump decimator and sits on the transmit path ahead of the DAC-side filters.
- Generates its own low-rate request strobe toward upstream, derived from the high-rate strobe_out.

---
 rtl/hold_interpolator.sv | 72 +++++++
 tb/tb_hold_interpolator.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hold_interpolator.sv
// hold_interpolator: upsamples a requested low-rate stream by rate+1 using zero-order hold or zero-stuffing.
module hold_interpolator #(
    parameter int bw = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    rate,
    input  logic          mode,
    input  logic          strobe_out,
    output logic          strobe_in,
    input  logic [bw-1:0] signal_in,
    output logic [bw-1:0] signal_out,
    output logic          underrun
);
    logic [7:0]    cnt_q, cnt_d;
    logic [bw-1:0] pending_q, pending_d, out_q, out_d;
    logic          req_q, req_d, cap_q, cap_d, ready_q, ready_d;
    logic          prime_q, prime_d, und_q, und_d;
    logic          tick, head, wrap;

    always_comb begin
        tick      = enable & strobe_out;
        head      = cnt_q == 8'd0;
        wrap      = cnt_q >= rate;
        cnt_d     = tick ? (wrap ? 8'd0 : cnt_q + 8'd1) : cnt_q;
        // a request is suppressed while one is already on the wire
        req_d     = ~req_q & (prime_q | (tick & wrap));
        prime_d   = 1'b0;
        cap_d     = req_q;
        pending_d = cap_q ? signal_in : pending_q;
        ready_d   = (cap_q | ready_q) & ~(tick & head);
        out_d     = !tick ? out_q : head ? (cap_q ? signal_in : pending_q) : mode ? '0 : out_q;
        und_d     = und_q | (tick & head & ~ready_q & ~cap_q);
        if (!enable) begin
            cnt_d     = 8'd0;
            req_d     = 1'b0;
            prime_d   = 1'b1;
            cap_d     = 1'b0;
            pending_d = '0;
            ready_d   = 1'b0;
            out_d     = '0;
            und_d     = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q     <= 8'd0;
            req_q     <= 1'b0;
            prime_q   <= 1'b1;
            cap_q     <= 1'b0;
            pending_q <= '0;
            ready_q   <= 1'b0;
            out_q     <= '0;
            und_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            prime_q   <= prime_d;
            cap_q     <= cap_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            out_q     <= out_d;
            und_q     <= und_d;
        end
    end

    assign strobe_in  = req_q;
    assign signal_out = out_q;
    assign underrun   = und_q;
endmodule

// File: tb/tb_hold_interpolator.sv
// tb_hold_interpolator: directed vectors for hold_interpolator with an upstream source answering strobe_in.
module tb_hold_interpolator;
    logic        clock, reset, enable, mode, strobe_out, strobe_in, underrun;
    logic [7:0]  rate;
    logic [15:0] signal_in, signal_out;
    logic [15:0] src[16];
    logic [15:0] exp_q[$];
    logic        und_hist[32];
    logic [3:0]  src_idx;
    int          reqs, vectors, miscompares;

    hold_interpolator #(.bw(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .rate(rate), .mode(mode),
        .strobe_out(strobe_out), .strobe_in(strobe_in), .signal_in(signal_in),
        .signal_out(signal_out), .underrun(underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // upstream answers a request with the next sample on the following clock
    task automatic step(input logic so);
        strobe_out = so;
        @(posedge clock);
        #1;
        strobe_out = 1'b0;
        if (strobe_in) begin
            signal_in = src[src_idx];
            src_idx++;
            reqs++;
        end
    endtask

    task automatic run(input logic [7:0] r, input logic m, input int per, input int n,
                       input int chg_at, input logic [7:0] chg_rate, input string tag);
        enable = 1'b0;
        step(1'b0);
        rate = r;
        mode = m;
        enable = 1'b1;
        src_idx = 4'd0;
        reqs = 0;
        repeat (3) step(1'b0);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s pre[%0d]", tag, k), signal_out, k == 0 ? 16'd0 : exp_q[k-1]);
            step(1'b1);
            check($sformatf("%s out[%0d]", tag, k), signal_out, exp_q[k]);
            und_hist[k] = underrun;
            if (k == chg_at) rate = chg_rate;
            repeat (per - 1) step(1'b0);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reqs = 0;
        src_idx = 4'd0;
        reset = 1'b0;
        enable = 1'b0;
        rate = 8'd0;
        mode = 1'b0;
        strobe_out = 1'b0;
        signal_in = 16'd0;
        for (int i = 0; i < 16; i++) src[i] = 16'd0;
        #12;
        check("reset out", signal_out, 16'd0);
        check("reset strobe_in", 16'(strobe_in), 16'd0);
        check("reset underrun", 16'(underrun), 16'd0);
        reset = 1'b1;

        src[0] = 16'd100; src[1] = 16'd200; src[2] = 16'hFFFB;
        exp_q = '{16'd100, 16'd100, 16'd100, 16'd100, 16'd200, 16'd200, 16'd200, 16'd200,
                  16'hFFFB, 16'hFFFB, 16'hFFFB, 16'hFFFB};
        run(8'd3, 1'b0, 4, 12, -1, 8'd0, "zoh");
        check("zoh reqs", 16'(reqs), 16'd4);
        check("zoh underrun", 16'(underrun), 16'd0);

        exp_q = '{16'd100, 16'd0, 16'd0, 16'd0, 16'd200, 16'd0, 16'd0, 16'd0,
                  16'hFFFB, 16'd0, 16'd0, 16'd0};
        run(8'd3, 1'b1, 4, 12, -1, 8'd0, "stuff");
        check("stuff reqs", 16'(reqs), 16'd4);

        for (int i = 0; i < 16; i++) src[i] = 16'(i + 1);
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        run(8'd0, 1'b0, 3, 6, -1, 8'd0, "pass");
        check("pass reqs", 16'(reqs), 16'd7);
        check("pass underrun", 16'(underrun), 16'd0);

        for (int i = 0; i < 16; i++) src[i] = 16'(i + 7);
        exp_q = '{16'd7, 16'd7, 16'd8, 16'd8, 16'd9, 16'd9};
        run(8'd0, 1'b0, 1, 6, -1, 8'd0, "fast");
        check("fast und0", 16'(und_hist[0]), 16'd0);
        check("fast und1", 16'(und_hist[1]), 16'd1);
        check("fast und5", 16'(und_hist[5]), 16'd1);
        enable = 1'b0;
        step(1'b0);
        check("disable out", signal_out, 16'd0);
        check("disable underrun", 16'(underrun), 16'd0);
        check("disable strobe_in", 16'(strobe_in), 16'd0);

        for (int i = 0; i < 16; i++) src[i] = 16'(11 * (i + 1));
        exp_q = '{16'd11, 16'd11, 16'd11, 16'd11, 16'd11, 16'd11, 16'd22, 16'd22, 16'd22,
                  16'd33, 16'd33, 16'd33, 16'd44};
        run(8'd7, 1'b0, 4, 13, 4, 8'd2, "rchg");
        check("rchg reqs", 16'(reqs), 16'd4);

        src[0] = 16'd100; src[1] = 16'd200;
        exp_q = '{16'd100, 16'd100};
        run(8'd3, 1'b0, 4, 2, -1, 8'd0, "arst");
        #2;
        reset = 1'b0;
        #1;
        check("arst out", signal_out, 16'd0);
        check("arst strobe_in", 16'(strobe_in), 16'd0);
        check("arst underrun", 16'(underrun), 16'd0);
        #2;
        reset = 1'b1;
        reqs = 0;
        step(1'b0);
        check("arst prime", 16'(strobe_in), 16'd1);
        step(1'b0);
        check("arst single", 16'(strobe_in), 16'd0);
        check("arst reqs", 16'(reqs), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
